// File: rtl/vector_register_file.sv
// Vector register file: NUM_REGS x (LANES x LANE_W) storage, two combinational read ports,
// one masked/broadcast write port, and a sequential zeroing sweep after every reset.
module vector_register_file #(
    parameter int NUM_REGS = 16,
    parameter int LANES    = 4,
    parameter int LANE_W   = 32,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS),
    localparam int VEC_W   = LANES * LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              we3,
    input  logic [LANES-1:0]  wmask3,
    input  logic              bcast3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [VEC_W-1:0]  wd3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [VEC_W-1:0]  rd1,
    output logic [VEC_W-1:0]  rd2
);

    localparam logic [ADDR_W:0]   NUM_REGS_W = NUM_REGS[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_REG   = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [VEC_W-1:0]    mem [NUM_REGS];
    logic [VEC_W-1:0]    wvec;
    logic                write_act;
    logic                ra1_ok;
    logic                ra2_ok;

    // Handshake: while ready=1 a write with we3=1 is taken at the rising edge and reads are
    // valid; while ready=0 writes are dropped and both read ports return zero.
    assign write_act = ready && we3 && ({1'b0, wa3} < NUM_REGS_W);
    assign ra1_ok    = {1'b0, ra1} < NUM_REGS_W;
    assign ra2_ok    = {1'b0, ra2} < NUM_REGS_W;

    always_comb begin
        wvec = '0;
        for (int i = 0; i < LANES; i++) begin
            wvec[i*LANE_W +: LANE_W] = bcast3 ? wd3[LANE_W-1:0] : wd3[i*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    mem[clr_cnt] <= '0;
                    clr_cnt      <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_REG) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (write_act) begin
                        for (int i = 0; i < LANES; i++) begin
                            if (wmask3[i]) begin
                                mem[wa3][i*LANE_W +: LANE_W] <= wvec[i*LANE_W +: LANE_W];
                            end
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Bypass overlays only the enabled lanes; the rest still come from storage.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ready) begin
            if (ra1_ok) rd1 = mem[ra1];
            if (ra2_ok) rd2 = mem[ra2];
            if (BYPASS != 0 && write_act) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wmask3[i] && ra1 == wa3) rd1[i*LANE_W +: LANE_W] = wvec[i*LANE_W +: LANE_W];
                    if (wmask3[i] && ra2 == wa3) rd2[i*LANE_W +: LANE_W] = wvec[i*LANE_W +: LANE_W];
                end
            end
        end
    end

endmodule
